// File: rtl/xor_selftest.sv
// Self-checker for an external XOR gate: applies 00,01,10,11, samples dut_c
// after SETTLE_CYCLES, and reports the results. Define XOR_SELFTEST_LOOP_EN to repeat passes forever.
module xor_selftest #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d, idx_inc;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d, err_sum;
  logic [3:0] fail_q, fail_d;
  logic       mismatch;
`ifdef XOR_SELFTEST_LOOP_EN
  logic       sticky_q, sticky_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    idx_inc  = idx_q + 2'd1;
    mismatch = dut_c ^ (a_q ^ b_q);
    err_sum  = err_q + {2'b00, mismatch};
`ifdef XOR_SELFTEST_LOOP_EN
    sticky_d = sticky_q;
`endif

    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          busy_d  = 1'b1;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end

      SAMPLE: begin
        err_d = err_sum;
        if (mismatch) fail_d[idx_q] = 1'b1;
        if (idx_q != 2'd3) begin
          idx_d      = idx_inc;
          {a_d, b_d} = idx_inc;
          cnt_d      = 8'd0;
          state_d    = SETTLE;
        end else begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
`ifdef XOR_SELFTEST_LOOP_EN
          // A single failing pass latches pass low until reset.
          sticky_d = sticky_q | (err_sum != 3'd0);
          pass_d   = (err_sum == 3'd0) && !sticky_q;
          busy_d   = 1'b1;
`else
          pass_d   = (err_sum == 3'd0);
          busy_d   = 1'b0;
`endif
        end
      end

      DONE: begin
`ifdef XOR_SELFTEST_LOOP_EN
        state_d = SETTLE;
        idx_d   = 2'd0;
        cnt_d   = 8'd0;
        err_d   = 3'd0;
        fail_d  = 4'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= 8'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= 4'd0;
`ifdef XOR_SELFTEST_LOOP_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
`ifdef XOR_SELFTEST_LOOP_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_xor_selftest.sv
// Bench for xor_selftest: a gate model with a per-vector fault mask drives dut_c,
// and the expected results are derived from that mask.
module tb_xor_selftest;

  localparam int S = 4;
  localparam int VEC_CYC = S + 1;
  localparam int PASS_EDGES = 4 * VEC_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_a, dut_b, dut_c;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] mask;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Gate under test: XOR, with output inverted for every vector whose mask bit is set.
  assign dut_c = (dut_a ^ dut_b) ^ mask[{dut_a, dut_b}];

  xor_selftest #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector driven in a cycle that is `pos` edges into a pass.
  function automatic logic [1:0] vec_at(input int pos);
    return (pos < PASS_EDGES) ? 2'(pos / VEC_CYC) : 2'b00;
  endfunction

  task automatic check_results(input string tag, input logic [3:0] m, input logic exp_pass);
    check({tag, " pass"}, 32'(pass), 32'(exp_pass));
    check({tag, " err_count"}, 32'(err_count), 32'($countones(m)));
    check({tag, " fail_vec"}, 32'(fail_vec), 32'(m));
  endtask

`ifndef XOR_SELFTEST_LOOP_EN
  // One pass with fault mask m. restart_at: edge index at which start is pulsed again
  // (-1 for none). reset_at: edge index after which rst_n is pulsed low (-1 for none).
  task automatic do_pass(input string tag, input logic [3:0] m,
                         input int restart_at, input int reset_at);
    int dones = 0;
    mask = m;
    for (int k = 0; k <= PASS_EDGES; k++) begin
      start = (k == 0) || (k == restart_at);
      tick();
      start = 1'b0;
      if (done) dones++;
      if (k < PASS_EDGES) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " ab"}, 32'({dut_a, dut_b}), 32'(vec_at(k)));
      end else begin
        check({tag, " done@end"}, 32'(done), 32'd1);
        check({tag, " busy@end"}, 32'(busy), 32'd0);
        check({tag, " ab@end"}, 32'({dut_a, dut_b}), 32'd0);
        check_results(tag, m, m == 4'd0);
      end
      if (k == reset_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check({tag, " rst outputs"},
              32'({dut_a, dut_b, busy, done, pass, err_count, fail_vec}), 32'd0);
        for (int j = 0; j < PASS_EDGES + 4; j++) begin
          tick();
          if (done) dones++;
        end
        check({tag, " rst no done"}, 32'(dones), 32'd0);
        check({tag, " rst idle busy"}, 32'(busy), 32'd0);
        return;
      end
    end
    tick();
    if (done) dones++;
    check({tag, " one done"}, 32'(dones), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check_results({tag, " hold"}, m, m == 4'd0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mask  = 4'd0;
    tick();
    tick();
    check("reset outputs", 32'({dut_a, dut_b, busy, done, pass, err_count, fail_vec}), 32'd0);
    rst_n = 1'b1;
    tick();

`ifndef XOR_SELFTEST_LOOP_EN
    do_pass("xor ok", 4'b0000, -1, -1);
    do_pass("stuck0", 4'b0110, -1, -1);
    do_pass("xnor", 4'b1111, -1, -1);
    do_pass("xor again", 4'b0000, -1, -1);
    do_pass("restart ignored", 4'b0000, 7, -1);
    do_pass("reset abort", 4'b1010, -1, 10);
    do_pass("after reset", 4'b0000, -1, -1);
    for (int r = 0; r < 6; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      do_pass($sformatf("random%0d", r), m, -1, -1);
    end
`else
    begin
      // Loop mode: one start, three passes; pass 2 carries a nonzero fault mask.
      logic [3:0] masks [3];
      logic       ok_so_far = 1'b1;
      int         period = PASS_EDGES + 1;
      int         dones = 0;
      int         busy_low = 0;
      masks[0] = 4'b0000;
      masks[1] = 4'($urandom_range(1, 15));
      masks[2] = 4'b0000;
      mask = masks[0];
      for (int k = 0; k < 3 * period; k++) begin
        int p;
        int pos;
        p   = k / period;
        pos = k % period;
        start = (k == 0);
        tick();
        start = 1'b0;
        if (!busy) busy_low++;
        if (done) dones++;
        check($sformatf("loop ab k%0d", k), 32'({dut_a, dut_b}), 32'(vec_at(pos)));
        if (pos == PASS_EDGES) begin
          ok_so_far = ok_so_far && (masks[p] == 4'd0);
          check($sformatf("loop done p%0d", p), 32'(done), 32'd1);
          check_results($sformatf("loop p%0d", p), masks[p], ok_so_far);
          if (p < 2) mask = masks[p + 1];
        end
      end
      check("loop done count", 32'(dones), 32'd3);
      check("loop busy low cycles", 32'(busy_low), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
